bcd_converter: RTL and testbench

BCD_CONVERTER -- requirements
Module: bcd_converter

---
 rtl/bcd_converter.sv | 99 +++++++++
 tb/tb_bcd_converter.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_converter.sv
// bcd_converter: sequential double-dabble binary to packed BCD,
// saturating at the largest value NUM_DIGITS digits can show.
module bcd_converter #(
  parameter int NUM_DIGITS = 8,
  parameter int BIN_WIDTH  = 27
) (
  input  logic                    Clk,
  input  logic                    Reset_n,
  input  logic                    start,
  input  logic [BIN_WIDTH-1:0]    bin,
  output logic                    busy,
  output logic                    done,
  output logic [4*NUM_DIGITS-1:0] encoded,
  output logic                    ovf
);

  localparam int DW = 4 * NUM_DIGITS;
  localparam int CW = $clog2(BIN_WIDTH + 1);

  function automatic logic [BIN_WIDTH-1:0] max_value();
    logic [BIN_WIDTH+3:0] p;
    p    = '0;
    p[0] = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++)
      p = p * (BIN_WIDTH+4)'(10);
    return BIN_WIDTH'(p - 1'b1);
  endfunction

  localparam logic [BIN_WIDTH-1:0] MAX_VAL = max_value();

  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    DONE
  } state_t;

  state_t               state;
  logic [BIN_WIDTH-1:0] sreg;
  logic [DW-1:0]        digits;
  logic [DW-1:0]        adj;
  logic [CW-1:0]        count;
  logic                 ovf_flag;
  logic                 too_big;

  assign too_big = bin > MAX_VAL;

  // every digit adjusted from its pre-shift value, no inter-digit carry
  always_comb begin
    adj = digits;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (digits[4*k +: 4] >= 4'd5)
        adj[4*k +: 4] = digits[4*k +: 4] + 4'd3;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state    <= IDLE;
      sreg     <= '0;
      digits   <= '0;
      count    <= '0;
      ovf_flag <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      encoded  <= '0;
      ovf      <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            sreg     <= too_big ? MAX_VAL : bin;
            ovf_flag <= too_big;
            digits   <= '0;
            count    <= CW'(BIN_WIDTH);
            busy     <= 1'b1;
            state    <= CONVERT;
          end
        end
        CONVERT: begin
          digits <= {adj[DW-2:0], sreg[BIN_WIDTH-1]};
          sreg   <= {sreg[BIN_WIDTH-2:0], 1'b0};
          count  <= count - 1'b1;
          if (count == CW'(1))
            state <= DONE;
        end
        DONE: begin
          encoded <= digits;
          ovf     <= ovf_flag;
          done    <= 1'b1;
          busy    <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_converter.sv
// tb_bcd_converter: directed and random checks of bcd_converter
// against an arithmetic decimal reference model.
module tb_bcd_converter;

  localparam int ND = 8;
  localparam int BW = 27;
  localparam int DW = 4 * ND;
  localparam longint MAXV = 64'd99999999;
  localparam int LAT = BW + 2;

  logic          Clk = 1'b0;
  logic          Reset_n;
  logic          start;
  logic [BW-1:0] bin;
  logic          busy;
  logic          done;
  logic [DW-1:0] encoded;
  logic          ovf;

  int total = 0;
  int bad   = 0;

  always #5 Clk = ~Clk;

  bcd_converter #(
    .NUM_DIGITS(ND),
    .BIN_WIDTH (BW)
  ) dut (
    .Clk    (Clk),
    .Reset_n(Reset_n),
    .start  (start),
    .bin    (bin),
    .busy   (busy),
    .done   (done),
    .encoded(encoded),
    .ovf    (ovf)
  );

  function automatic void model(input longint v,
                                output logic [DW-1:0] e,
                                output logic o);
    longint s;
    o = (v > MAXV);
    s = o ? MAXV : v;
    e = '0;
    for (int k = 0; k < ND; k++) begin
      e[4*k +: 4] = 4'(s % 10);
      s = s / 10;
    end
  endfunction

  task automatic run(input logic [BW-1:0] v,
                     output logic [DW-1:0] e,
                     output logic o);
    logic [DW-1:0] pe;
    logic          po;
    bit            moved;
    int            lat;
    @(negedge Clk);
    pe = encoded;
    po = ovf;
    bin = v;
    start = 1'b1;
    @(negedge Clk);
    start = 1'b0;
    bin = BW'($urandom);
    lat = 1;
    moved = 0;
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL busy_start: got %b want 1", busy);
    end
    while (done !== 1'b1 && lat < 60) begin
      if (encoded !== pe || ovf !== po) moved = 1;
      @(negedge Clk);
      lat++;
    end
    e = encoded;
    o = ovf;
    total++;
    if (moved) begin
      bad++;
      $display("FAIL hold: outputs changed before done, want %h", pe);
    end
    total++;
    if (lat !== LAT) begin
      bad++;
      $display("FAIL latency: got %0d want %0d", lat, LAT);
    end
    @(negedge Clk);
    total++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL pulse: done=%b busy=%b want 0 0", done, busy);
    end
  endtask

  task automatic test_reset();
    logic [DW-1:0] e;
    logic          o;
    Reset_n = 1'b1;
    start = 1'b0;
    bin = '0;
    #2 Reset_n = 1'b0;
    #1;
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || encoded !== '0 || ovf !== 1'b0) begin
      bad++;
      $display("FAIL reset: busy=%b done=%b enc=%h ovf=%b want 0 0 0 0",
               busy, done, encoded, ovf);
    end
    repeat (3) @(negedge Clk);
    Reset_n = 1'b1;
    run(BW'(5), e, o);
    total++;
    if (e !== 32'h0000_0005 || o !== 1'b0) begin
      bad++;
      $display("FAIL first_start: got %h/%b want 00000005/0", e, o);
    end
  endtask

  task automatic test_directed();
    logic [BW-1:0] vin [5];
    logic [DW-1:0] exp_e [5];
    logic          exp_o [5];
    logic [DW-1:0] e;
    logic          o;
    vin = '{BW'(0), BW'(12345678), BW'(99999999), BW'(100000000), BW'(7)};
    exp_e = '{32'h0000_0000, 32'h1234_5678, 32'h9999_9999,
              32'h9999_9999, 32'h0000_0007};
    exp_o = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 5; i++) begin
      run(vin[i], e, o);
      total++;
      if (e !== exp_e[i] || o !== exp_o[i]) begin
        bad++;
        $display("FAIL directed[%0d]: bin=%0d got %h/%b want %h/%b",
                 i, vin[i], e, o, exp_e[i], exp_o[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int times [$];
    int n;
    @(negedge Clk);
    bin = BW'(42);
    start = 1'b1;
    for (int c = 1; c <= 120; c++) begin
      @(negedge Clk);
      if (done === 1'b1) begin
        times.push_back(c);
        total++;
        if (encoded !== 32'h0000_0042 || ovf !== 1'b0) begin
          bad++;
          $display("FAIL b2b_value: got %h/%b want 00000042/0", encoded, ovf);
        end
      end
    end
    start = 1'b0;
    n = times.size();
    total++;
    if (n !== 4) begin
      bad++;
      $display("FAIL b2b_count: got %0d want 4", n);
    end
    for (int i = 1; i < n; i++) begin
      total++;
      if (times[i] - times[i-1] !== LAT) begin
        bad++;
        $display("FAIL b2b_period: got %0d want %0d",
                 times[i] - times[i-1], LAT);
      end
    end
    repeat (LAT + 2) @(negedge Clk);
  endtask

  task automatic test_ignore_start();
    int ndone;
    logic [DW-1:0] last;
    ndone = 0;
    last = '0;
    @(negedge Clk);
    bin = BW'(31415926);
    start = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      @(negedge Clk);
      start = (c == 5 || c == 15);
      bin = BW'(c * 1000);
      if (done === 1'b1) begin
        ndone++;
        last = encoded;
      end
    end
    start = 1'b0;
    total++;
    if (ndone !== 1) begin
      bad++;
      $display("FAIL ignore_count: got %0d want 1", ndone);
    end
    total++;
    if (last !== 32'h3141_5926) begin
      bad++;
      $display("FAIL ignore_value: got %h want 31415926", last);
    end
  endtask

  task automatic test_reset_abort();
    logic [DW-1:0] e;
    logic          o;
    int            ndone;
    run(BW'(100000000), e, o);
    @(negedge Clk);
    bin = BW'(87654321);
    start = 1'b1;
    @(negedge Clk);
    start = 1'b0;
    repeat (9) @(negedge Clk);
    Reset_n = 1'b0;
    #1;
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || encoded !== '0 || ovf !== 1'b0) begin
      bad++;
      $display("FAIL abort: busy=%b done=%b enc=%h ovf=%b want 0 0 0 0",
               busy, done, encoded, ovf);
    end
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
    ndone = 0;
    repeat (40) begin
      @(negedge Clk);
      if (done === 1'b1) ndone++;
    end
    total++;
    if (ndone !== 0 || encoded !== '0) begin
      bad++;
      $display("FAIL abort_quiet: done pulses %0d enc %h want 0 0",
               ndone, encoded);
    end
    run(BW'(87654321), e, o);
    total++;
    if (e !== 32'h8765_4321 || o !== 1'b0) begin
      bad++;
      $display("FAIL abort_rerun: got %h/%b want 87654321/0", e, o);
    end
  endtask

  task automatic test_random();
    logic [BW-1:0] v;
    logic [DW-1:0] e, me;
    logic          o, mo;
    bit            bad_nib;
    for (int i = 0; i < 1000; i++) begin
      if (i == 0)
        v = '1;
      else if ($urandom_range(3) == 0)
        v = BW'(MAXV - 50 + longint'($urandom_range(100)));
      else
        v = BW'($urandom_range((1 << BW) - 1));
      run(v, e, o);
      model(longint'(v), me, mo);
      total++;
      if (e !== me || o !== mo) begin
        bad++;
        $display("FAIL random: bin=%0d got %h/%b want %h/%b",
                 v, e, o, me, mo);
      end
      bad_nib = 0;
      for (int k = 0; k < ND; k++)
        if (e[4*k +: 4] > 4'd9) bad_nib = 1;
      total++;
      if (bad_nib) begin
        bad++;
        $display("FAIL nibble: bin=%0d got %h want all digits <= 9", v, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_ignore_start();
    test_reset_abort();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
